read_dma_scheduler: RTL and testbench
=====================================

READ_DMA_SCHEDULER -- requirements
Module: read_dma_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024: max cycles to wait for completion after start (range 2..65535).
REQ-002 SHALL have ports, in this order:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- i_enable  in  1  scheduler enable.
- i_req  in  2  per-channel job request, level; bit0 = ch0.
- i_ch0_len  in  6  ch0 buffer length in words.
- i_ch0_addr  in  32  ch0 DMA start address.
- i_ch1_len  in  6  ch1 buffer length in words.
- i_ch1_addr  in  32  ch1 DMA start address.
- i_slave_done  in  1  read-slave completion flag, level.
- o_ReadSystemStart  out  1  one-cycle start pulse to the DMA master.
- o_RCC_BUFFER_LENGTH  out  6  latched length.
- o_RCC_DMA_ADDR_HIGH  out  16  latched address [31:16].
- o_RCC_DMA_ADDR_LOW  out  16  latched address [15:0].
- o_grant  out  2  one-hot owner of the current job.
- o_ack  out  2  one-cycle completion pulse to the owner.
- o_err  out  1  one-cycle timeout pulse, coincident with o_ack.
- o_busy  out  1  high in any state except IDLE.
- o_job_cnt  out  16  count of completed jobs.

Function
REQ-003 SHALL implement states IDLE, LATCH, START, WAIT, DONE, all registered on HCLK.
REQ-004 IDLE: if i_enable=1 and i_req!=0, SHALL arbitrate, set o_grant, latch the winner's length/address into the o_RCC_* registers and go to LATCH; otherwise stay in IDLE.
REQ-005 Arbitration SHALL be round-robin via a last-grant pointer (reset = ch1, so ch0 wins first).
- Single requester wins regardless of pointer.
- Simultaneous requests go to the channel not equal to the pointer.
- Pointer updates in DONE.
REQ-006 LATCH: o_RCC_* SHALL be stable for ≥1 cycle before the start pulse.
- Latched length = 0: go directly to DONE, no start pulse.
- Else go to START.
REQ-007 START: o_ReadSystemStart SHALL be 1 for exactly this one cycle; clear the timeout counter; go to WAIT.
REQ-008 WAIT: completion SHALL be a rising edge of i_slave_done (compared with its previous-cycle value); a level already high on WAIT entry SHALL NOT complete the job.
REQ-009 WAIT: timeout counter SHALL increment each cycle; at TIMEOUT_CYC-1 without completion go to DONE with the error flag set.
REQ-010 Completion edge and timeout in the same cycle SHALL count as normal completion (o_err=0).
REQ-011 DONE (one cycle): SHALL pulse o_ack on the granted bit, pulse o_err if timed out, increment o_job_cnt (16-bit wrap 0xFFFF->0x0000), update the pointer, clear o_grant next cycle, return to IDLE.
REQ-012 o_grant SHALL hold one-hot from LATCH through DONE; o_RCC_* SHALL hold their values until the next latch.
REQ-013 Input changes after latch SHALL NOT affect the running job:
- deasserting i_req, changing length/address, or i_enable=0 after LATCH.
- i_enable gates only new arbitration.
REQ-014 Minimum IDLE-to-IDLE job duration SHALL be 5 cycles (nonzero length, immediate done edge); back-to-back jobs SHALL re-arbitrate in IDLE with no further gap.

Reset
REQ-015 HRESETn low SHALL asynchronously force:
- state = IDLE; pointer = ch1.
- o_ReadSystemStart, o_ack, o_err, o_busy, o_grant = 0.
- o_RCC_* = 0; o_job_cnt = 0; timeout counter = 0.
- done-edge history = 0.
REQ-016 Reset in any state SHALL abort the job with no o_ack; first arbitration after release takes ≥1 HCLK.

Verification
REQ-017 ch0 only (len=8, addr=0x1234_5678); i_slave_done rises 10 cycles after start -> start pulse once, HIGH=0x1234, LOW=0x5678, o_ack=01 one cycle, o_job_cnt=1.
REQ-018 i_req=11 held through 4 jobs -> grant order ch0, ch1, ch0, ch1; o_job_cnt=4.
REQ-019 TIMEOUT_CYC=16, i_slave_done stuck 0 -> o_ack and o_err pulse together 16 cycles after start; state returns to IDLE.
REQ-020 ch1 len=0 -> no o_ReadSystemStart, o_ack=10 in DONE, o_err=0.
REQ-021 i_slave_done held high from a prior job, new job started -> no completion until it falls and rises again.
REQ-022 HRESETn asserted in WAIT -> all outputs 0 immediately, no o_ack; o_job_cnt preset to 0xFFFF then one completion -> 0x0000.

Source files
------------

// File: rtl/read_dma_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : read_dma_scheduler
// Purpose  : Two-channel round-robin scheduler that hands read jobs to a DMA
//            master. A winning channel's length/address are latched onto the
//            RCC register outputs, the master gets a one-cycle start pulse and
//            the scheduler then waits for a rising edge on the read-slave
//            completion flag (or a timeout) before acknowledging the owner.
//
// Ports    :
//   HCLK                 in   1   clock
//   HRESETn              in   1   asynchronous active-low reset
//   i_enable             in   1   gates new arbitration only
//   i_req                in   2   per-channel job request (level), bit0 = ch0
//   i_ch0_len/i_ch0_addr in   6/32  ch0 buffer length (words) / start address
//   i_ch1_len/i_ch1_addr in   6/32  ch1 buffer length (words) / start address
//   i_slave_done         in   1   read-slave completion flag (level)
//   o_ReadSystemStart    out  1   one-cycle start pulse to the DMA master
//   o_RCC_BUFFER_LENGTH  out  6   latched length
//   o_RCC_DMA_ADDR_HIGH  out  16  latched address [31:16]
//   o_RCC_DMA_ADDR_LOW   out  16  latched address [15:0]
//   o_grant              out  2   one-hot owner of the current job
//   o_ack                out  2   one-cycle completion pulse to the owner
//   o_err                out  1   one-cycle timeout pulse (with o_ack)
//   o_busy               out  1   high whenever not idle
//   o_job_cnt            out  16  completed job count (wraps)
//
// Revision : 1.0  initial release
// ============================================================================
module read_dma_scheduler #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        i_enable,
    input  logic [1:0]  i_req,
    input  logic [5:0]  i_ch0_len,
    input  logic [31:0] i_ch0_addr,
    input  logic [5:0]  i_ch1_len,
    input  logic [31:0] i_ch1_addr,
    input  logic        i_slave_done,
    output logic        o_ReadSystemStart,
    output logic [5:0]  o_RCC_BUFFER_LENGTH,
    output logic [15:0] o_RCC_DMA_ADDR_HIGH,
    output logic [15:0] o_RCC_DMA_ADDR_LOW,
    output logic [1:0]  o_grant,
    output logic [1:0]  o_ack,
    output logic        o_err,
    output logic        o_busy,
    output logic [15:0] o_job_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Final value the wait counter reaches when the job times out.
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_last_ch1;    // last-grant pointer: 1 = ch1 was served last
    logic [1:0]  r_grant;
    logic [5:0]  r_len;
    logic [31:0] r_addr;
    logic [15:0] r_job_cnt;
    logic [15:0] r_to_cnt;
    logic        r_done_d;      // previous-cycle i_slave_done for edge detect
    logic        r_err;

    logic        w_req_any;
    logic        w_pick_ch1;
    logic        w_edge;
    logic [15:0] w_cnt_nxt;
    logic        w_timeout;

    logic        w_start;
    logic [1:0]  w_ack;
    logic        w_err;
    logic        w_busy;

    assign w_req_any = i_enable && (i_req != 2'b00);

    // A lone requester always wins; when both request, serve the channel
    // that was not served last.
    assign w_pick_ch1 = i_req[1] & (~i_req[0] | ~r_last_ch1);

    // Only a genuine low-to-high transition completes a job, so a flag left
    // high by the previous job cannot finish the new one.
    assign w_edge    = i_slave_done & ~r_done_d;
    assign w_cnt_nxt = r_to_cnt + 16'd1;
    assign w_timeout = (w_cnt_nxt == c_TO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ack       = 2'b00;
        w_err       = 1'b0;
        w_busy      = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_req_any) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                // Zero-length jobs never reach the DMA master.
                if (r_len == 6'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_start     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A completion edge in the timeout cycle still counts as a
                // normal completion; the error flag is handled below.
                if (w_edge || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_ack       = r_grant;
                w_err       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job datapath: grant, latched parameters, timeout, counters
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last_ch1 <= 1'b1;
            r_grant    <= 2'b00;
            r_len      <= 6'd0;
            r_addr     <= 32'd0;
            r_job_cnt  <= 16'd0;
            r_to_cnt   <= 16'd0;
            r_done_d   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done_d <= i_slave_done;

            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        if (w_pick_ch1) begin
                            r_grant <= 2'b10;
                            r_len   <= i_ch1_len;
                            r_addr  <= i_ch1_addr;
                        end else begin
                            r_grant <= 2'b01;
                            r_len   <= i_ch0_len;
                            r_addr  <= i_ch0_addr;
                        end
                    end
                end
                S_LATCH: begin
                    // Clear here so a zero-length job cannot inherit a
                    // stale error from an earlier timed-out job.
                    r_err <= 1'b0;
                end
                S_START: begin
                    r_to_cnt <= 16'd0;
                    r_err    <= 1'b0;
                end
                S_WAIT: begin
                    r_to_cnt <= w_cnt_nxt;
                    if (w_timeout && !w_edge) begin
                        r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_job_cnt  <= r_job_cnt + 16'd1;
                    r_last_ch1 <= r_grant[1];
                    r_grant    <= 2'b00;
                end
                default: begin
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign o_ReadSystemStart   = w_start;
    assign o_RCC_BUFFER_LENGTH = r_len;
    assign o_RCC_DMA_ADDR_HIGH = r_addr[31:16];
    assign o_RCC_DMA_ADDR_LOW  = r_addr[15:0];
    assign o_grant             = r_grant;
    assign o_ack               = w_ack;
    assign o_err               = w_err;
    assign o_busy              = w_busy;
    assign o_job_cnt           = r_job_cnt;

endmodule
`default_nettype wire

// File: tb/tb_read_dma_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_dma_scheduler
// Purpose  : Directed self-checking bench for read_dma_scheduler with
//            hand-computed expectations (TIMEOUT_CYC = 16).
// Revision : 1.0  initial release
// ============================================================================
module tb_read_dma_scheduler;

    localparam int TO = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        i_enable = 1'b0;
    logic [1:0]  i_req = 2'b00;
    logic [5:0]  i_ch0_len = 6'd0;
    logic [31:0] i_ch0_addr = 32'd0;
    logic [5:0]  i_ch1_len = 6'd0;
    logic [31:0] i_ch1_addr = 32'd0;
    logic        i_slave_done = 1'b0;

    logic        o_ReadSystemStart;
    logic [5:0]  o_RCC_BUFFER_LENGTH;
    logic [15:0] o_RCC_DMA_ADDR_HIGH;
    logic [15:0] o_RCC_DMA_ADDR_LOW;
    logic [1:0]  o_grant;
    logic [1:0]  o_ack;
    logic        o_err;
    logic        o_busy;
    logic [15:0] o_job_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;

    read_dma_scheduler #(.TIMEOUT_CYC(TO)) dut (
        .HCLK                (HCLK),
        .HRESETn             (HRESETn),
        .i_enable            (i_enable),
        .i_req               (i_req),
        .i_ch0_len           (i_ch0_len),
        .i_ch0_addr          (i_ch0_addr),
        .i_ch1_len           (i_ch1_len),
        .i_ch1_addr          (i_ch1_addr),
        .i_slave_done        (i_slave_done),
        .o_ReadSystemStart   (o_ReadSystemStart),
        .o_RCC_BUFFER_LENGTH (o_RCC_BUFFER_LENGTH),
        .o_RCC_DMA_ADDR_HIGH (o_RCC_DMA_ADDR_HIGH),
        .o_RCC_DMA_ADDR_LOW  (o_RCC_DMA_ADDR_LOW),
        .o_grant             (o_grant),
        .o_ack               (o_ack),
        .o_err               (o_err),
        .o_busy              (o_busy),
        .o_job_cnt           (o_job_cnt)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (o_ReadSystemStart) n_starts++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 ns after the rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn      = 1'b0;
        i_req        = 2'b00;
        i_enable     = 1'b0;
        i_slave_done = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        tick();
    endtask

    // Runs one job from IDLE with requests already driven. The done flag
    // rises after (delay+1) WAIT-side ticks; delay=0 is the 5-cycle minimum.
    task automatic run_job(input logic [1:0] exp_g, input int delay);
        i_slave_done = 1'b0;
        tick();
        chk("rr_grant", {30'd0, o_grant}, {30'd0, exp_g});
        tick();
        chk("rr_start", {31'd0, o_ReadSystemStart}, 32'd1);
        repeat (delay + 1) tick();
        i_slave_done = 1'b1;
        tick();
        chk("rr_ack", {30'd0, o_ack}, {30'd0, exp_g});
        chk("rr_err", {31'd0, o_err}, 32'd0);
        i_slave_done = 1'b0;
        tick();
        chk("rr_idle_busy", {31'd0, o_busy}, 32'd0);
        chk("rr_idle_grant", {30'd0, o_grant}, 32'd0);
    endtask

    initial begin
        int cyc;
        int starts_snap;
        i_ch0_addr = 32'h1234_5678;
        i_ch1_addr = 32'hCAFE_0040;

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_busy",  {31'd0, o_busy}, 32'd0);
        chk("rst_grant", {30'd0, o_grant}, 32'd0);
        chk("rst_start", {31'd0, o_ReadSystemStart}, 32'd0);
        chk("rst_ack",   {30'd0, o_ack}, 32'd0);
        chk("rst_err",   {31'd0, o_err}, 32'd0);
        chk("rst_cnt",   {16'd0, o_job_cnt}, 32'd0);
        chk("rst_len",   {26'd0, o_RCC_BUFFER_LENGTH}, 32'd0);
        chk("rst_addr",  {o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW}, 32'd0);

        // ---------------- ch0 single job, inputs change after latch -------
        i_ch0_len = 6'd8;
        i_enable  = 1'b1;
        i_req     = 2'b01;
        tick();
        chk("t1_grant", {30'd0, o_grant}, 32'd1);
        chk("t1_busy",  {31'd0, o_busy}, 32'd1);
        chk("t1_len",   {26'd0, o_RCC_BUFFER_LENGTH}, 32'd8);
        chk("t1_high",  {16'd0, o_RCC_DMA_ADDR_HIGH}, 32'h1234);
        chk("t1_low",   {16'd0, o_RCC_DMA_ADDR_LOW}, 32'h5678);
        chk("t1_nostart", {31'd0, o_ReadSystemStart}, 32'd0);
        i_req      = 2'b00;
        i_enable   = 1'b0;
        i_ch0_len  = 6'd3;
        i_ch0_addr = 32'd0;
        tick();
        chk("t1_start", {31'd0, o_ReadSystemStart}, 32'd1);
        repeat (9) tick();
        chk("t1_wait_ack", {30'd0, o_ack}, 32'd0);
        i_slave_done = 1'b1;
        tick();
        chk("t1_ack", {30'd0, o_ack}, 32'd1);
        chk("t1_err", {31'd0, o_err}, 32'd0);
        tick();
        i_slave_done = 1'b0;
        chk("t1_cnt",    {16'd0, o_job_cnt}, 32'd1);
        chk("t1_ackoff", {30'd0, o_ack}, 32'd0);
        chk("t1_gntoff", {30'd0, o_grant}, 32'd0);
        chk("t1_hold_len",  {26'd0, o_RCC_BUFFER_LENGTH}, 32'd8);
        chk("t1_hold_addr", {o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW}, 32'h1234_5678);
        chk("t1_nstarts", n_starts, 32'd1);
        i_ch0_len  = 6'd8;
        i_ch0_addr = 32'h1234_5678;

        // ---------------- round robin, back-to-back ----------------
        do_reset();
        i_ch0_len = 6'd4;
        i_ch1_len = 6'd5;
        i_enable  = 1'b1;
        i_req     = 2'b11;
        run_job(2'b01, 0);
        run_job(2'b10, 0);
        run_job(2'b01, 1);
        run_job(2'b10, 0);
        i_req = 2'b00;
        chk("rr_cnt", {16'd0, o_job_cnt}, 32'd4);

        // ---------------- done edge coincident with timeout ----------------
        i_ch0_len = 6'd8;
        i_req     = 2'b01;
        tick();
        i_req = 2'b00;
        tick();
        chk("tb_start", {31'd0, o_ReadSystemStart}, 32'd1);
        repeat (15) tick();
        i_slave_done = 1'b1;
        tick();
        chk("tb_ack", {30'd0, o_ack}, 32'd1);
        chk("tb_err", {31'd0, o_err}, 32'd0);
        i_slave_done = 1'b0;
        tick();

        // ---------------- timeout ----------------
        i_req = 2'b10;
        tick();
        chk("to_grant", {30'd0, o_grant}, 32'd2);
        i_req = 2'b00;
        tick();
        chk("to_start", {31'd0, o_ReadSystemStart}, 32'd1);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_ack == 2'b00 && cyc < 40);
        chk("to_cycles", cyc, TO);
        chk("to_ack", {30'd0, o_ack}, 32'd2);
        chk("to_err", {31'd0, o_err}, 32'd1);
        tick();
        chk("to_idle", {31'd0, o_busy}, 32'd0);
        chk("to_erroff", {31'd0, o_err}, 32'd0);

        // ---------------- zero-length job ----------------
        i_ch1_len   = 6'd0;
        starts_snap = n_starts;
        i_req       = 2'b10;
        tick();
        chk("z_grant", {30'd0, o_grant}, 32'd2);
        i_req = 2'b00;
        tick();
        chk("z_ack",   {30'd0, o_ack}, 32'd2);
        chk("z_err",   {31'd0, o_err}, 32'd0);
        chk("z_start", {31'd0, o_ReadSystemStart}, 32'd0);
        tick();
        chk("z_nstarts", n_starts, starts_snap);
        chk("z_busy", {31'd0, o_busy}, 32'd0);

        // ---------------- done held high from before ----------------
        i_slave_done = 1'b1;
        i_req        = 2'b01;
        tick();
        i_req = 2'b00;
        tick();
        repeat (5) tick();
        chk("hi_noack", {30'd0, o_ack}, 32'd0);
        chk("hi_busy",  {31'd0, o_busy}, 32'd1);
        i_slave_done = 1'b0;
        tick();
        chk("hi_noack2", {30'd0, o_ack}, 32'd0);
        i_slave_done = 1'b1;
        tick();
        chk("hi_ack", {30'd0, o_ack}, 32'd1);
        i_slave_done = 1'b0;
        tick();

        // ---------------- reset during WAIT ----------------
        i_req = 2'b01;
        tick();
        i_req = 2'b00;
        tick();
        tick();
        tick();
        #2;
        HRESETn = 1'b0;
        #1;
        chk("ar_busy",  {31'd0, o_busy}, 32'd0);
        chk("ar_grant", {30'd0, o_grant}, 32'd0);
        chk("ar_ack",   {30'd0, o_ack}, 32'd0);
        chk("ar_cnt",   {16'd0, o_job_cnt}, 32'd0);
        chk("ar_len",   {26'd0, o_RCC_BUFFER_LENGTH}, 32'd0);
        chk("ar_addr",  {o_RCC_DMA_ADDR_HIGH, o_RCC_DMA_ADDR_LOW}, 32'd0);
        tick();
        chk("ar_ack_hold", {30'd0, o_ack}, 32'd0);
        HRESETn = 1'b1;
        tick();
        chk("ar_post_busy", {31'd0, o_busy}, 32'd0);

        // ---------------- job counter wrap ----------------
        force dut.r_job_cnt = 16'hFFFF;
        #1;
        release dut.r_job_cnt;
        chk("wr_preset", {16'd0, o_job_cnt}, 32'h0000_FFFF);
        i_req = 2'b10;
        tick();
        i_req = 2'b00;
        tick();
        chk("wr_ack", {30'd0, o_ack}, 32'd2);
        tick();
        chk("wr_cnt", {16'd0, o_job_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
